bp_be_dcache_pkt_arbiter: RTL

//  Shares the single-ported D$ SRAM access slot among the three LCE fill/evict packet

---
 rtl/bp_be_dcache_pkg.sv | 21 ++
 rtl/bp_be_rr_arb3.sv | 42 ++++
 rtl/bp_be_dcache_pkt_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bp_be_dcache_pkg.sv
// Shared types for the D$ packet arbiter: SRAM channel select encoding and helpers.
package bp_be_dcache_pkg;

  typedef enum logic [1:0] {
    e_sram_sel_data = 2'b00,
    e_sram_sel_tag  = 2'b01,
    e_sram_sel_stat = 2'b10
  } bp_be_dcache_sram_sel_e;

  localparam int unsigned lce_chan_num_lp = 3;

  // One-hot channel grant {stat, tag, data} to the SRAM select encoding.
  function automatic bp_be_dcache_sram_sel_e onehot_to_sel(input logic [2:0] oh);
    bp_be_dcache_sram_sel_e sel;
    sel = e_sram_sel_data;
    if (oh[1]) sel = e_sram_sel_tag;
    if (oh[2]) sel = e_sram_sel_stat;
    return sel;
  endfunction

endpackage

// File: rtl/bp_be_rr_arb3.sv
// Three-requester round-robin arbiter. The pointer names the requester with
// highest priority next time; it advances past the winner whenever a grant
// is actually issued (en_i with at least one request).
module bp_be_rr_arb3
  import bp_be_dcache_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic [2:0] req_i,
  output logic [2:0] grant_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [2:0] pick;
  logic [1:0] win;

  // Pick the first requester at or after the pointer, wrapping data->tag->stat.
  always_comb begin
    pick = '0;
    win  = ptr_q;
    for (int i = lce_chan_num_lp - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr_q) + i) % lce_chan_num_lp;
      if (req_i[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
        win       = 2'(idx);
      end
    end
    grant_o = en_i ? pick : 3'b000;
    ptr_d   = ptr_q;
    if (en_i && (|req_i)) ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
  end

  // Pointer register; reset points at the data channel.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= 2'd0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bp_be_dcache_pkt_arbiter.sv
// Shares the single D$ SRAM slot between the BE pipe and the three LCE packet
// channels. The pipe has priority until an LCE packet has waited starve_limit_p
// cycles; read data returns the cycle after a grant and is held per channel.
module bp_be_dcache_pkt_arbiter
  import bp_be_dcache_pkg::*;
#(
  parameter int data_pkt_width_p = 100,
  parameter int tag_pkt_width_p  = 40,
  parameter int stat_pkt_width_p = 16,
  parameter int block_width_p    = 512,
  parameter int ptag_width_p     = 28,
  parameter int stat_width_p     = 15,
  parameter int starve_limit_p   = 16,
  localparam int pkt_max0_lp     = (data_pkt_width_p > tag_pkt_width_p) ? data_pkt_width_p : tag_pkt_width_p,
  localparam int pkt_width_lp    = (pkt_max0_lp > stat_pkt_width_p) ? pkt_max0_lp : stat_pkt_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        data_mem_pkt_v_i,
  input  logic [data_pkt_width_p-1:0] data_mem_pkt_i,
  output logic                        data_mem_pkt_yumi_o,
  output logic [block_width_p-1:0]    data_mem_o,
  input  logic                        tag_mem_pkt_v_i,
  input  logic [tag_pkt_width_p-1:0]  tag_mem_pkt_i,
  output logic                        tag_mem_pkt_yumi_o,
  output logic [ptag_width_p-1:0]     tag_mem_o,
  input  logic                        stat_mem_pkt_v_i,
  input  logic [stat_pkt_width_p-1:0] stat_mem_pkt_i,
  output logic                        stat_mem_pkt_yumi_o,
  output logic [stat_width_p-1:0]     stat_mem_o,
  input  logic                        pipe_req_v_i,
  output logic                        pipe_stall_o,
  output logic                        sram_v_o,
  output logic [1:0]                  sram_sel_o,
  output logic [pkt_width_lp-1:0]     sram_pkt_o,
  input  logic [block_width_p-1:0]    sram_rdata_i
);

  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);

  logic [2:0]             lce_req, grant;
  logic                   lce_v, lce_go;
  logic [cnt_w_lp-1:0]    starve_cnt_q, starve_cnt_d;
  logic                   rd_v_q, rd_v_d;
  bp_be_dcache_sram_sel_e rd_sel_q, rd_sel_d, win_sel;
  logic [block_width_p-1:0] data_hold_q, data_hold_d;
  logic [ptag_width_p-1:0]  tag_hold_q, tag_hold_d;
  logic [stat_width_p-1:0]  stat_hold_q, stat_hold_d;

  assign lce_req = {stat_mem_pkt_v_i, tag_mem_pkt_v_i, data_mem_pkt_v_i};
  assign lce_v   = |lce_req;
  // Gated by reset so every output is quiet while reset is held.
  assign lce_go  = reset_n_i & lce_v
                 & (~pipe_req_v_i | (starve_cnt_q == cnt_w_lp'(starve_limit_p)));
  assign pipe_stall_o = pipe_req_v_i & lce_go;

  bp_be_rr_arb3 u_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (lce_go),
    .req_i     (lce_req),
    .grant_o   (grant)
  );

  assign data_mem_pkt_yumi_o = grant[0];
  assign tag_mem_pkt_yumi_o  = grant[1];
  assign stat_mem_pkt_yumi_o = grant[2];
  assign win_sel             = onehot_to_sel(grant);
  assign sram_v_o            = lce_go;
  assign sram_sel_o          = lce_go ? win_sel : e_sram_sel_data;

  // Route the winning packet to the SRAM, zero-extended to the widest packet.
  always_comb begin
    sram_pkt_o = '0;
    unique case (grant)
      3'b001:  sram_pkt_o[data_pkt_width_p-1:0] = data_mem_pkt_i;
      3'b010:  sram_pkt_o[tag_pkt_width_p-1:0]  = tag_mem_pkt_i;
      3'b100:  sram_pkt_o[stat_pkt_width_p-1:0] = stat_mem_pkt_i;
      default: sram_pkt_o = '0;
    endcase
  end

  // Starvation counter: cleared on an LCE grant, counts cycles an LCE waits behind the pipe.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (lce_go)
      starve_cnt_d = '0;
    else if (lce_v && pipe_req_v_i && (starve_cnt_q != cnt_w_lp'(starve_limit_p)))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Read response: bypass SRAM data to the channel granted last cycle, else show the hold value.
  always_comb begin
    rd_v_d     = lce_go;
    rd_sel_d   = win_sel;
    data_mem_o = data_hold_q;
    tag_mem_o  = tag_hold_q;
    stat_mem_o = stat_hold_q;
    if (rd_v_q) begin
      unique case (rd_sel_q)
        e_sram_sel_data: data_mem_o = sram_rdata_i;
        e_sram_sel_tag:  tag_mem_o  = sram_rdata_i[ptag_width_p-1:0];
        e_sram_sel_stat: stat_mem_o = sram_rdata_i[stat_width_p-1:0];
        default: ;
      endcase
    end
    data_hold_d = data_mem_o;
    tag_hold_d  = tag_mem_o;
    stat_hold_d = stat_mem_o;
  end

  // State registers; reset drops any read in flight and clears the hold values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_q <= '0;
      rd_v_q       <= 1'b0;
      rd_sel_q     <= e_sram_sel_data;
      data_hold_q  <= '0;
      tag_hold_q   <= '0;
      stat_hold_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_v_q       <= rd_v_d;
      rd_sel_q     <= rd_sel_d;
      data_hold_q  <= data_hold_d;
      tag_hold_q   <= tag_hold_d;
      stat_hold_q  <= stat_hold_d;
    end
  end

endmodule
